// File: rtl/instr_fetch_prefetch_if.sv
// Fetch-unit bus: instruction RAM request/response plus the core-side
// prefetch handshake and redirect controls.
interface instr_fetch_prefetch_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);

  // Core-side control
  logic                    fetch_enable_i;
  logic                    branch_i;
  logic [ADDR_WIDTH-1:0]   branch_addr_i;

  // Instruction RAM port
  logic                    mem_en_o;
  logic [ADDR_WIDTH-1:0]   mem_addr_o;
  logic                    mem_we_o;
  logic [DATA_WIDTH/8-1:0] mem_be_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic [DATA_WIDTH-1:0]   mem_rdata_i;

  // Decode-side handshake
  logic                    instr_valid_o;
  logic                    instr_ready_i;
  logic [DATA_WIDTH-1:0]   instr_rdata_o;
  logic [ADDR_WIDTH-1:0]   instr_addr_o;

  // Fetch unit side
  modport master (
    input  fetch_enable_i,
    input  branch_i,
    input  branch_addr_i,
    output mem_en_o,
    output mem_addr_o,
    output mem_we_o,
    output mem_be_o,
    output mem_wdata_o,
    input  mem_rdata_i,
    output instr_valid_o,
    input  instr_ready_i,
    output instr_rdata_o,
    output instr_addr_o
  );

  // Environment side (RAM + core)
  modport slave (
    output fetch_enable_i,
    output branch_i,
    output branch_addr_i,
    input  mem_en_o,
    input  mem_addr_o,
    input  mem_we_o,
    input  mem_be_o,
    input  mem_wdata_o,
    output mem_rdata_i,
    input  instr_valid_o,
    output instr_ready_i,
    input  instr_rdata_o,
    input  instr_addr_o
  );

endinterface

// File: rtl/instr_fetch_prefetch.sv
// Instruction fetch with a small prefetch FIFO. Issues sequential word reads
// to a 1-cycle registered RAM, tracks the single in-flight response and
// flushes buffered/in-flight words on a branch redirect.
module instr_fetch_prefetch #(
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rstn_i,
  instr_fetch_prefetch_if.master bus
);

  localparam int unsigned Stride = DATA_WIDTH / 8;
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  // One extra bit so count + pend never wraps in the space test
  localparam int unsigned OccW   = CntW + 1;

  localparam logic [ADDR_WIDTH-1:0] OffMask     = ADDR_WIDTH'(Stride - 1);
  localparam logic [ADDR_WIDTH-1:0] StrideA     = ADDR_WIDTH'(Stride);
  localparam logic [ADDR_WIDTH-1:0] BootAligned = BOOT_ADDR & ~OffMask;
  localparam logic [PtrW-1:0]       LastPtr     = PtrW'(FIFO_DEPTH - 1);

  // Fetch address / in-flight tracking
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;

  // Prefetch FIFO
  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;

  logic                  pop;
  logic                  push;
  logic                  space_ok;
  logic [OccW-1:0]       occupancy;
  logic [ADDR_WIDTH-1:0] branch_tgt;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;

  // Request issue and next fetch address
  always_comb begin
    mem_en       = 1'b0;
    mem_addr     = fetch_addr_q;
    fetch_addr_d = fetch_addr_q;
    pop          = (count_q != '0) && bus.instr_ready_i;
    // A response landing in a branch cycle belongs to the old path
    push         = pend_q && !bus.branch_i;
    branch_tgt   = bus.branch_addr_i & ~OffMask;
    occupancy    = OccW'(count_q) + OccW'(pend_q) - OccW'(pop);
    space_ok     = occupancy < OccW'(FIFO_DEPTH);

    if (bus.branch_i) begin
      mem_en       = bus.fetch_enable_i;
      mem_addr     = branch_tgt;
      fetch_addr_d = bus.fetch_enable_i ? (branch_tgt + StrideA) : branch_tgt;
    end else if (bus.fetch_enable_i && space_ok) begin
      mem_en       = 1'b1;
      fetch_addr_d = fetch_addr_q + StrideA;
    end

    // Request must drop the moment reset asserts, not at the next edge
    if (!rstn_i) begin
      mem_en = 1'b0;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (bus.branch_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Fetch address and in-flight request registers
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_addr_q <= BootAligned;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      pend_q       <= mem_en;
      pend_addr_q  <= mem_addr;
    end
  end

  // FIFO control registers
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; RAM data is only valid the cycle after the request
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (push) begin
      data_q[wptr_q] <= bus.mem_rdata_i;
      addr_q[wptr_q] <= pend_addr_q;
    end
  end

  assign bus.mem_en_o      = mem_en;
  assign bus.mem_addr_o    = mem_addr;
  assign bus.mem_we_o      = 1'b0;
  assign bus.mem_be_o      = '1;
  assign bus.mem_wdata_o   = '0;
  assign bus.instr_valid_o = (count_q != '0);
  assign bus.instr_rdata_o = data_q[rptr_q];
  assign bus.instr_addr_o  = addr_q[rptr_q];

endmodule

// File: tb/tb_instr_fetch_prefetch.sv
// Bench for instr_fetch_prefetch: RAM model with word i = 0x100 + i, an
// address-ordered scoreboard fed from the bench's own fetch-address model,
// directed cycle checks and a random ready/enable/branch phase.
module tb_instr_fetch_prefetch;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } ent_t;

  logic clk;
  logic rstn;

  int n_vec;
  int n_err;

  ent_t          exp_q[$];
  logic [AW-1:0] exp_addr;

  instr_fetch_prefetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_fetch_prefetch #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .BOOT_ADDR (8'h00)
  ) dut (
    .clk   (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return 32'h100 + DW'(a >> 2);
  endfunction

  // RAM: registered read, output updates every clock
  always @(posedge clk) begin
    if (bus.mem_en_o) bus.mem_rdata_i <= ram_word(bus.mem_addr_o);
    else              bus.mem_rdata_i <= $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop before branch flush, push requests after it
  always @(negedge clk) begin
    ent_t e;
    if (!rstn) begin
      exp_q.delete();
      exp_addr = 8'h00;
    end else begin
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pop_addr", 32'(bus.instr_addr_o), 32'(e.addr));
          chk("pop_data", bus.instr_rdata_o, e.data);
        end
      end
      if (bus.branch_i) begin
        exp_q.delete();
        exp_addr = bus.branch_addr_i & 8'hFC;
      end
      if (bus.mem_en_o) begin
        chk("req_enable", 32'(bus.fetch_enable_i), 32'd1);
        chk("req_addr", 32'(bus.mem_addr_o), 32'(exp_addr));
        exp_q.push_back('{data: ram_word(exp_addr), addr: exp_addr});
        exp_addr = exp_addr + 8'd4;
      end
    end
  end

  initial begin
    logic prev_br;
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    bus.fetch_enable_i = 1'b1;
    bus.instr_ready_i  = 1'b1;
    bus.branch_i       = 1'b0;
    bus.branch_addr_i  = '0;

    // Reset state and first fetches
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en", 32'(bus.mem_en_o), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("const_we", 32'(bus.mem_we_o), 32'd0);
    chk("const_be", 32'(bus.mem_be_o), 32'hF);
    chk("const_wdata", bus.mem_wdata_o, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("c0_mem_en", 32'(bus.mem_en_o), 32'd1);
    chk("c0_addr", 32'(bus.mem_addr_o), 32'h00);
    chk("c0_valid", 32'(bus.instr_valid_o), 32'd0);
    @(negedge clk);
    chk("c1_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("c1_addr", 32'(bus.mem_addr_o), 32'h04);
    @(negedge clk);
    chk("c2_valid", 32'(bus.instr_valid_o), 32'd1);
    chk("c2_data", bus.instr_rdata_o, 32'h100);
    chk("c2_iaddr", 32'(bus.instr_addr_o), 32'h00);
    @(negedge clk);
    chk("c3_data", bus.instr_rdata_o, 32'h101);
    chk("c3_iaddr", 32'(bus.instr_addr_o), 32'h04);
    @(negedge clk);
    chk("c4_data", bus.instr_rdata_o, 32'h102);
    chk("c4_iaddr", 32'(bus.instr_addr_o), 32'h08);

    // Core stall: FIFO fills to depth and requests stop
    tick();
    bus.instr_ready_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("stall_mem_en", 32'(bus.mem_en_o), 32'd0);
    chk("stall_valid", 32'(bus.instr_valid_o), 32'd1);
    chk("stall_depth", 32'(exp_q.size()), 32'(DEPTH));
    tick();
    bus.instr_ready_i = 1'b1;
    repeat (6) tick();

    // Branch from a full FIFO to an unaligned target
    bus.instr_ready_i = 1'b0;
    repeat (3) tick();
    bus.branch_i      = 1'b1;
    bus.branch_addr_i = 8'h43;
    bus.instr_ready_i = 1'b1;
    @(negedge clk);
    chk("br_mem_en", 32'(bus.mem_en_o), 32'd1);
    chk("br_addr", 32'(bus.mem_addr_o), 32'h40);
    tick();
    bus.branch_i = 1'b0;
    @(negedge clk);
    chk("br_flush_valid", 32'(bus.instr_valid_o), 32'd0);
    @(negedge clk);
    chk("br_first_valid", 32'(bus.instr_valid_o), 32'd1);
    chk("br_first_data", bus.instr_rdata_o, 32'h110);
    chk("br_first_iaddr", 32'(bus.instr_addr_o), 32'h40);
    repeat (4) tick();

    // Address wrap at the top of the byte space
    bus.branch_i      = 1'b1;
    bus.branch_addr_i = 8'hF8;
    @(negedge clk);
    chk("wrap_a0", 32'(bus.mem_addr_o), 32'hF8);
    tick();
    bus.branch_i = 1'b0;
    @(negedge clk);
    chk("wrap_a1", 32'(bus.mem_addr_o), 32'hFC);
    @(negedge clk);
    chk("wrap_a2", 32'(bus.mem_addr_o), 32'h00);
    chk("wrap_i0", 32'(bus.instr_addr_o), 32'hF8);
    @(negedge clk);
    chk("wrap_a3", 32'(bus.mem_addr_o), 32'h04);
    chk("wrap_i1", 32'(bus.instr_addr_o), 32'hFC);
    @(negedge clk);
    chk("wrap_i2", 32'(bus.instr_addr_o), 32'h00);

    // Enable dropped right after a request
    tick();
    bus.fetch_enable_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dis_mem_en", 32'(bus.mem_en_o), 32'd0);
    end
    tick();
    bus.fetch_enable_i = 1'b1;
    repeat (5) tick();

    // Reset mid-stream with a response in flight
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_mem_en", 32'(bus.mem_en_o), 32'd0);
    chk("arst_valid", 32'(bus.instr_valid_o), 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_mem_en", 32'(bus.mem_en_o), 32'd1);
    chk("rel_addr", 32'(bus.mem_addr_o), 32'h00);
    @(negedge clk);
    chk("rel_valid_c1", 32'(bus.instr_valid_o), 32'd0);
    @(negedge clk);
    chk("rel_iaddr", 32'(bus.instr_addr_o), 32'h00);
    chk("rel_data", bus.instr_rdata_o, 32'h100);

    // Random ready / enable / branch traffic
    prev_br = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      bus.instr_ready_i  = ($urandom_range(0, 3) != 0);
      bus.fetch_enable_i = ($urandom_range(0, 7) != 0);
      bus.branch_i       = !prev_br && ($urandom_range(0, 15) == 0);
      bus.branch_addr_i  = 8'($urandom);
      prev_br            = bus.branch_i;
    end

    // Drain: everything requested must come out
    tick();
    bus.branch_i       = 1'b0;
    bus.fetch_enable_i = 1'b0;
    bus.instr_ready_i  = 1'b1;
    repeat (10) tick();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(bus.instr_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
